// File: rtl/ascon_aead128_pkg.sv
// Shared types and constants for the Ascon-AEAD128 datapath.
// Holds the block padder FSM encoding, padding byte and rate size.
package ascon_aead128_pkg;

  // Block padder control states.
  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    PAD_EMIT = 2'd2
  } padder_fsm_state;

  // Ascon padding marker appended after the last message byte.
  localparam logic [7:0] PAD_BYTE   = 8'h01;
  // Rate of Ascon-AEAD128 in bytes.
  localparam logic [4:0] RATE_BYTES = 5'd16;

  // Number of consecutive valid bytes in a keep mask, counted from bit 0.
  function automatic logic [2:0] keep_len(input logic [3:0] keep);
    logic [2:0] len;
    if (!keep[0])      len = 3'd0;
    else if (!keep[1]) len = 3'd1;
    else if (!keep[2]) len = 3'd2;
    else if (!keep[3]) len = 3'd3;
    else               len = 3'd4;
    return len;
  endfunction

endpackage

// File: rtl/ascon_pad_insert.sv
// Combinational padding insertion: keeps the first n bytes of the buffer,
// places the padding byte at position n and zeroes everything above it.
// With n = 16 the buffer passes through unchanged.
module ascon_pad_insert
  import ascon_aead128_pkg::*;
(
  input  logic [127:0] buf_in,
  input  logic [4:0]   n_bytes,
  output logic [127:0] block
);

  // Per-byte select between message data, padding marker and zero.
  always_comb begin
    block = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < n_bytes) begin
        block[8*i +: 8] = buf_in[8*i +: 8];
      end else if (5'(i) == n_bytes) begin
        block[8*i +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/ascon_block_padder.sv
// Ascon block padder: packs 32-bit input words into 128-bit rate blocks,
// appends the 0x01 padding byte on the final block of a message and emits
// an extra padding-only block when the message ends exactly on a block
// boundary.
// Optional feature: define ASCON_PADDER_STATS_EN to add the blk_count output
// (16-bit wrapping count of output handshakes).
module ascon_block_padder
  import ascon_aead128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic [3:0]   s_keep,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] m_block,
  output logic [4:0]   m_bytes,
  output logic         m_last,
  output logic         m_valid,
  input  logic         m_ready
`ifdef ASCON_PADDER_STATS_EN
  ,
  output logic [15:0]  blk_count
`endif
);

  padder_fsm_state state_q, state_d;
  logic [1:0]      widx_q, widx_d;
  logic [127:0]    buf_q, buf_d;
  logic [127:0]    blk_q, blk_d;
  logic [4:0]      bytes_q, bytes_d;
  logic            last_q, last_d;
  // Set when a full 16-byte final block still owes a padding-only block.
  logic            pad_pend_q, pad_pend_d;

  logic            s_fire;
  logic            m_fire;
  logic [2:0]      beat_bytes;
  logic [4:0]      n_total;
  logic [127:0]    buf_wr;
  logic [127:0]    padded;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  // Only the last beat may be partial; earlier beats always count as 4 bytes.
  assign beat_bytes = s_last ? keep_len(s_keep) : 3'd4;
  assign n_total    = {1'b0, widx_q, 2'b00} + {2'b00, beat_bytes};

  // Buffer as it looks with the current input word merged into its slot.
  always_comb begin
    buf_wr = buf_q;
    buf_wr[{widx_q, 5'b00000} +: 32] = s_data;
  end

  ascon_pad_insert u_pad_insert (
    .buf_in  (buf_wr),
    .n_bytes (n_total),
    .block   (padded)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      widx_q     <= 2'd0;
      buf_q      <= '0;
      blk_q      <= '0;
      bytes_q    <= 5'd0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      buf_q      <= buf_d;
      blk_q      <= blk_d;
      bytes_q    <= bytes_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    buf_d      = buf_q;
    blk_d      = blk_q;
    bytes_d    = bytes_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;

    unique case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_fire) begin
          buf_d  = buf_wr;
          widx_d = widx_q + 2'd1;
          if (s_last || (widx_q == 2'd3)) begin
            state_d    = EMIT;
            blk_d      = padded;
            bytes_d    = n_total;
            last_d     = s_last && (n_total != RATE_BYTES);
            pad_pend_d = s_last && (n_total == RATE_BYTES);
          end
        end
      end

      EMIT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (pad_pend_q) begin
            state_d    = PAD_EMIT;
            blk_d      = {120'd0, PAD_BYTE};
            bytes_d    = 5'd0;
            last_d     = 1'b1;
            pad_pend_d = 1'b0;
          end else begin
            state_d    = FILL;
            widx_d     = 2'd0;
            buf_d      = '0;
            blk_d      = '0;
            bytes_d    = 5'd0;
            last_d     = 1'b0;
            pad_pend_d = 1'b0;
          end
        end
      end

      PAD_EMIT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d    = FILL;
          widx_d     = 2'd0;
          buf_d      = '0;
          blk_d      = '0;
          bytes_d    = 5'd0;
          last_d     = 1'b0;
          pad_pend_d = 1'b0;
        end
      end

      default: begin
        state_d    = FILL;
        widx_d     = 2'd0;
        buf_d      = '0;
        blk_d      = '0;
        bytes_d    = 5'd0;
        last_d     = 1'b0;
        pad_pend_d = 1'b0;
      end
    endcase
  end

  assign m_block = blk_q;
  assign m_bytes = bytes_q;
  assign m_last  = last_q;

`ifdef ASCON_PADDER_STATS_EN
  logic [15:0] blk_count_q;

  // Count output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_q <= 16'd0;
    end else if (m_fire) begin
      blk_count_q <= blk_count_q + 16'd1;
    end
  end

  assign blk_count = blk_count_q;
`else
  // Handshake strobe has no consumer without the statistics counter.
  logic unused_m_fire;
  assign unused_m_fire = m_fire;
`endif

endmodule

// File: doc/ascon_block_padder.md
ASCON_BLOCK_PADDER -- requirements
Module: ascon_block_padder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port s_data, input, 32, input word; byte j at bits [8j+7:8j].
REQ-004 SHALL have port s_keep, input, 4, valid-byte mask for s_data; bytes are contiguous from LSB.
REQ-005 SHALL have port s_last, input, 1, marks the final word of the message (AD or plaintext).
REQ-006 SHALL have ports s_valid (input, 1) and s_ready (output, 1), input handshake.
REQ-007 SHALL have port m_block, output, 128, padded 128-bit rate block, little-endian byte order.
REQ-008 SHALL have port m_bytes, output, 5, count of message bytes in m_block (0..16), excluding padding.
REQ-009 SHALL have port m_last, output, 1, marks the final block of the message.
REQ-010 SHALL have ports m_valid (output, 1) and m_ready (input, 1), output handshake toward the Ascon core.

Function
REQ-011 SHALL transfer on s_valid&&s_ready and on m_valid&&m_ready only.
REQ-012 SHALL use FSM states FILL, EMIT, PAD_EMIT.
REQ-013 FILL: s_ready=1, m_valid=0; each accepted word is written into bits [32k+31:32k], k = word index 0..3.
REQ-014 Byte count of a beat SHALL be the number of consecutive ones in s_keep from bit 0; non-last beats SHALL be treated as 4 bytes regardless of s_keep.
REQ-015 Block completes on the 4th accepted word or on s_last; FSM goes FILL->EMIT the next cycle with m_valid=1 (1-cycle latency).
REQ-016 On completion with n<16 total bytes: byte n = 8'h01, bytes n+1..15 = 0, m_bytes=n, m_last=s_last.
REQ-017 On completion with n=16 and s_last=1: emit full block with m_last=0, then EMIT->PAD_EMIT with m_block=128'h01, m_bytes=0, m_last=1.
REQ-018 Full block (n=16) without s_last: m_last=0, no padding byte.
REQ-019 s_last with s_keep=0 as first beat of a block SHALL produce block 128'h01, m_bytes=0, m_last=1 (empty message or empty tail).
REQ-020 EMIT/PAD_EMIT: s_ready=0; m_block, m_bytes, m_last, m_valid SHALL be held stable until m_ready.
REQ-021 EMIT->FILL (or ->PAD_EMIT per REQ-017) and PAD_EMIT->FILL on m_ready; block buffer and word index cleared on return to FILL.

Reset
REQ-022 On rst_n low, immediately: state=FILL, word index=0, buffer=0, m_valid=0, m_last=0, m_bytes=0, m_block=0; s_ready=1 after release.
REQ-023 Reset mid-block or mid-EMIT SHALL discard the partial/pending block without emitting it.

Configuration
REQ-024 With ASCON_PADDER_STATS_EN defined, SHALL add output blk_count[15:0], incremented on each output handshake, wrapping 16'hFFFF->0, reset to 0.
REQ-025 Without ASCON_PADDER_STATS_EN, port blk_count and its counter SHALL be absent; behaviour otherwise identical.

Structure
REQ-026 ascon_aead128_pkg SHALL gain padder_fsm_state enum (FILL, EMIT, PAD_EMIT), PAD_BYTE=8'h01, RATE_BYTES=16.
REQ-027 Padding insertion (buffer, n) -> padded block SHALL be a combinational sub-module ascon_pad_insert.

Verification
REQ-028 Words 03020100,07060504,0B0A0908,0F0E0D0C, s_last on 4th, keep=F -> block 0F0E..0100, m_last=0, m_bytes=16, then 128'h01, m_bytes=0, m_last=1.
REQ-029 One word 0xDDCCBBAA, keep=4'b0111, s_last -> m_block=128'h01CCBBAA, m_bytes=3, m_last=1, m_valid one cycle after accept.
REQ-030 s_last, keep=0, first beat -> m_block=128'h01, m_bytes=0, m_last=1.
REQ-031 m_ready held low 10 cycles in EMIT -> outputs stable, s_ready=0 throughout; single transfer on release.
REQ-032 rst_n pulsed after 2 accepted words -> no block emitted; next 5-byte message yields m_bytes=5, byte 5=01.
REQ-033 With ASCON_PADDER_STATS_EN, 20-byte message -> blk_count=2 after both blocks transferred.
